peridot_dualboot_responder: RTL and testbench

- Avalon-MM responder for the dual-boot configuration register interface on the FPGA's configuration block.
- Serves the initiator-side remote-update sequencer in place of the vendor dual-boot IP, for simulation and for non-MAX 10 builds.
- Emulates status-read busy timing, the msm_cs boot status register and reconfiguration triggering.
- Cycle-accurate to the register map below so the sequencer can be exercised unmodified.

---
 rtl/peridot_dualboot_responder_pkg.sv | 26 ++
 rtl/peridot_dualboot_responder_if.sv | 26 ++
 rtl/peridot_dualboot_responder.sv | 138 +++++++++++++
 tb/tb_peridot_dualboot_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/peridot_dualboot_responder_pkg.sv
// Shared definitions for the dual-boot register responder and its sequencer.
package peridot_dualboot_pkg;

  localparam logic [2:0] ADDR_TRIG   = 3'h0;
  localparam logic [2:0] ADDR_REQ    = 3'h2;
  localparam logic [2:0] ADDR_BUSY   = 3'h3;
  localparam logic [2:0] ADDR_STATUS = 3'h4;

  localparam int MSM_CS_LSB = 13;
  localparam int MSM_CS_MSB = 16;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    BUSY        = 2'd1,
    RECONF_WAIT = 2'd2,
    HALT        = 2'd3
  } state_t;

  // Initiator-side image decode: bit15 differing from bit13 selects image1.
  function automatic logic status_is_image1(input logic [31:0] status);
    return status[15] ^ status[13];
  endfunction

endpackage

// File: rtl/peridot_dualboot_responder_if.sv
// Avalon-MM register bus between the remote-update sequencer and the responder.
interface peridot_dualboot_responder_if;

  logic [2:0]  avmm_address;
  logic        avmm_write;
  logic [31:0] avmm_writedata;
  logic        avmm_read;
  logic [31:0] avmm_readdata;

  modport master (
    output avmm_address,
    output avmm_write,
    output avmm_writedata,
    output avmm_read,
    input  avmm_readdata
  );

  modport slave (
    input  avmm_address,
    input  avmm_write,
    input  avmm_writedata,
    input  avmm_read,
    output avmm_readdata
  );

endinterface

// File: rtl/peridot_dualboot_responder.sv
// Dual-boot configuration block stand-in: status-read busy timing, msm_cs
// capture and delayed reconfiguration request.
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | accepts status-capture and reconfig-trigger writes
// BUSY        | status read in progress, counting down CONFIG_CYCLE
// RECONF_WAIT | reconfig triggered, counting down RESET_TIMER_CYCLE
// HALT        | reconfig_req held high until reset or nreset low
module peridot_dualboot_responder
  import peridot_dualboot_pkg::*;
#(
  parameter int unsigned CONFIG_CYCLE      = 28,
  parameter int unsigned RESET_TIMER_CYCLE = 40
) (
  input  logic                               clock_sig,
  input  logic                               reset_sig,
  input  logic                               nreset,
  peridot_dualboot_responder_if.slave        avmm,
  input  logic [3:0]                         cfg_msm_cs,
  output logic                               busy,
  output logic                               reconfig_req
);

  localparam logic [CNT_W-1:0] CONFIG_LOAD = CNT_W'(CONFIG_CYCLE - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_TIMER_CYCLE - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;
  logic [3:0]        status_q, status_d;
  logic              busy_q, busy_d;
  logic              reconf_q, reconf_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0]       status_word;
  logic              wr_req, wr_trig;
  logic              wdata_unused;

  assign wdata_unused = ^avmm.avmm_writedata[31:1];

  assign wr_req  = avmm.avmm_write && (avmm.avmm_address == ADDR_REQ)  && avmm.avmm_writedata[0];
  assign wr_trig = avmm.avmm_write && (avmm.avmm_address == ADDR_TRIG) && avmm.avmm_writedata[0];

  // Place the captured msm_cs into its field; every other status bit is zero.
  always_comb begin
    status_word = '0;
    status_word[MSM_CS_MSB:MSM_CS_LSB] = status_q;
  end

  // Next-state, down-counter, capture and read-data selection.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    status_d  = status_q;
    busy_d    = busy_q;
    reconf_d  = reconf_q;
    rdata_d   = rdata_q;

    // Reads observe pre-edge state, so a same-cycle write is not yet visible.
    if (avmm.avmm_read) begin
      unique case (avmm.avmm_address)
        ADDR_BUSY:   rdata_d = {31'b0, busy_q};
        ADDR_STATUS: rdata_d = status_word;
        default:     rdata_d = '0;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (wr_req) begin
          counter_d = CONFIG_LOAD;
          busy_d    = 1'b1;
          state_d   = BUSY;
        end else if (wr_trig) begin
          counter_d = RESET_LOAD;
          state_d   = RECONF_WAIT;
        end
      end
      BUSY: begin
        if (counter_q == '0) begin
          status_d = cfg_msm_cs;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      RECONF_WAIT: begin
        if (counter_q == '0) begin
          reconf_d = 1'b1;
          state_d  = HALT;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      HALT: begin
        reconf_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Initiator-driven interface disable wins over any in-flight sequence.
    if (!nreset) begin
      state_d   = IDLE;
      counter_d = '0;
      status_d  = '0;
      busy_d    = 1'b0;
      reconf_d  = 1'b0;
      rdata_d   = '0;
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q   <= IDLE;
      counter_q <= '0;
      status_q  <= '0;
      busy_q    <= 1'b0;
      reconf_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
      reconf_q  <= reconf_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avmm.avmm_readdata = rdata_q;
  assign busy               = busy_q;
  assign reconfig_req       = reconf_q;

endmodule

// File: tb/tb_peridot_dualboot_responder.sv
// Directed bench for the dual-boot responder: busy timing, capture, reconfig, nreset.
module tb_peridot_dualboot_responder;
  import peridot_dualboot_pkg::*;

  logic       clock_sig;
  logic       reset_sig;
  logic       nreset;
  logic [3:0] cfg_msm_cs;
  logic       busy;
  logic       reconfig_req;

  int checks   = 0;
  int failures = 0;

  peridot_dualboot_responder_if avmm_bus ();

  peridot_dualboot_responder #(
    .CONFIG_CYCLE      (28),
    .RESET_TIMER_CYCLE (40)
  ) dut (
    .clock_sig    (clock_sig),
    .reset_sig    (reset_sig),
    .nreset       (nreset),
    .avmm         (avmm_bus.slave),
    .cfg_msm_cs   (cfg_msm_cs),
    .busy         (busy),
    .reconfig_req (reconfig_req)
  );

  initial clock_sig = 1'b0;
  always #5 clock_sig = ~clock_sig;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_sig);
    #1;
  endtask

  task automatic bus_idle();
    avmm_bus.avmm_address   = 3'h0;
    avmm_bus.avmm_write     = 1'b0;
    avmm_bus.avmm_writedata = 32'h0;
    avmm_bus.avmm_read      = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] addr, input logic [31:0] data);
    avmm_bus.avmm_address   = addr;
    avmm_bus.avmm_writedata = data;
    avmm_bus.avmm_write     = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic do_read(input logic [2:0] addr, output logic [31:0] data);
    avmm_bus.avmm_address = addr;
    avmm_bus.avmm_read    = 1'b1;
    tick();
    data = avmm_bus.avmm_readdata;
    bus_idle();
  endtask

  // Counts clocks with busy high; optionally re-issues a request at clock extra_at.
  task automatic measure_busy(input int extra_at, output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == extra_at) begin
        avmm_bus.avmm_address   = ADDR_REQ;
        avmm_bus.avmm_writedata = 32'h1;
        avmm_bus.avmm_write     = 1'b1;
      end
      tick();
      bus_idle();
    end
  endtask

  task automatic nreset_pulse();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  logic [31:0] rd;
  int          n;
  int          hold_ok;

  initial begin
    reset_sig  = 1'b1;
    nreset     = 1'b1;
    cfg_msm_cs = 4'b0000;
    bus_idle();
    #23;
    check_val("rst_busy", {31'b0, busy}, 32'h0);
    check_val("rst_req", {31'b0, reconfig_req}, 32'h0);
    check_val("rst_rdata", avmm_bus.avmm_readdata, 32'h0);
    reset_sig = 1'b0;
    tick();

    do_read(ADDR_STATUS, rd);
    check_val("rst_rd_status", rd, 32'h0);
    do_read(ADDR_BUSY, rd);
    check_val("rst_rd_busy", rd, 32'h0);

    // Capture 0100: image1.
    cfg_msm_cs = 4'b0100;
    do_write(ADDR_REQ, 32'h1);
    measure_busy(0, n);
    check_val("busy_len_0100", n, 28);
    do_read(ADDR_BUSY, rd);
    check_val("poll_done_0100", rd, 32'h0);
    do_read(ADDR_STATUS, rd);
    check_val("status_0100", rd, 32'h0000_8000);
    check_val("image_0100", {31'b0, status_is_image1(rd)}, 32'h1);

    // Capture 0101 with a second request mid-busy: image0, length unchanged.
    cfg_msm_cs = 4'b0101;
    do_write(ADDR_REQ, 32'h1);
    measure_busy(5, n);
    check_val("busy_len_rewrite", n, 28);
    do_read(ADDR_STATUS, rd);
    check_val("status_0101", rd, 32'h0000_A000);
    check_val("image_0101", {31'b0, status_is_image1(rd)}, 32'h0);

    // Terminal-clock sampling and pre-edge read of the status register.
    cfg_msm_cs = 4'b0100;
    do_write(ADDR_REQ, 32'h1);           // write edge E0
    do_read(ADDR_BUSY, rd);              // edge E1
    check_val("poll_busy_mid", rd, 32'h1);
    repeat (18) tick();                  // through E19
    cfg_msm_cs = 4'b0011;
    repeat (7) tick();                   // through E26
    do_read(ADDR_STATUS, rd);            // E27
    check_val("status_before_term", rd, 32'h0000_A000);
    do_read(ADDR_STATUS, rd);            // E28, terminal edge
    check_val("status_at_term_edge", rd, 32'h0000_A000);
    check_val("busy_after_term", {31'b0, busy}, 32'h0);
    do_read(ADDR_STATUS, rd);
    check_val("status_0011", rd, 32'h0000_6000);
    check_val("image_0011", {31'b0, status_is_image1(rd)}, 32'h1);

    // Address held for two back-to-back reads, then readdata holds.
    do_read(ADDR_BUSY, rd);
    avmm_bus.avmm_address = ADDR_STATUS;
    avmm_bus.avmm_read    = 1'b1;
    tick();
    check_val("b2b_rd1", avmm_bus.avmm_readdata, 32'h0000_6000);
    tick();
    check_val("b2b_rd2", avmm_bus.avmm_readdata, 32'h0000_6000);
    bus_idle();
    hold_ok = 1;
    repeat (3) begin
      tick();
      if (avmm_bus.avmm_readdata !== 32'h0000_6000) hold_ok = 0;
    end
    check_val("rdata_hold", hold_ok, 1);

    // Unmapped reads return zero.
    for (int a = 5; a < 8; a++) begin
      do_read(ADDR_STATUS, rd);
      do_read(3'(a), rd);
      check_val($sformatf("rd_addr%0d", a), rd, 32'h0);
    end

    // Ignored writes: other addresses and bit0 clear.
    do_write(3'h1, 32'h1);
    do_write(3'h7, 32'hFFFF_FFFF);
    do_write(ADDR_REQ, 32'h2);
    do_write(ADDR_TRIG, 32'hFFFF_FFFE);
    repeat (45) tick();
    check_val("ign_wr_busy", {31'b0, busy}, 32'h0);
    check_val("ign_wr_req", {31'b0, reconfig_req}, 32'h0);
    do_read(ADDR_STATUS, rd);
    check_val("ign_wr_status", rd, 32'h0000_6000);

    // Read and write in one cycle: read returns pre-write state.
    do_read(ADDR_BUSY, rd);
    avmm_bus.avmm_address   = ADDR_BUSY;
    avmm_bus.avmm_read      = 1'b1;
    tick();
    avmm_bus.avmm_address   = ADDR_REQ;
    avmm_bus.avmm_read      = 1'b0;
    avmm_bus.avmm_writedata = 32'h1;
    avmm_bus.avmm_write     = 1'b1;
    tick();                              // E0 of a new request
    bus_idle();
    avmm_bus.avmm_address = ADDR_BUSY;
    avmm_bus.avmm_read    = 1'b1;
    avmm_bus.avmm_writedata = 32'h1;
    avmm_bus.avmm_write   = 1'b0;
    tick();                              // E1: sees busy=1 pre-edge
    bus_idle();
    check_val("rd_busy_after_wr", rd, 32'h0);
    check_val("rd_busy_e1", avmm_bus.avmm_readdata, 32'h1);

    // nreset low mid-BUSY at counter==10 (after E17).
    repeat (16) tick();                  // through E17
    nreset_pulse();
    check_val("nrst_busy", {31'b0, busy}, 32'h0);
    do_read(ADDR_STATUS, rd);
    check_val("nrst_status", rd, 32'h0);
    hold_ok = 1;
    repeat (40) begin
      tick();
      if (busy !== 1'b0) hold_ok = 0;
    end
    check_val("nrst_stays_idle", hold_ok, 1);

    // nreset low mid-RECONF_WAIT: reconfig never asserts.
    do_write(ADDR_TRIG, 32'h1);
    repeat (20) tick();
    nreset_pulse();
    hold_ok = 1;
    repeat (60) begin
      tick();
      if (reconfig_req !== 1'b0) hold_ok = 0;
    end
    check_val("nrst_reconf_abort", hold_ok, 1);

    // Full reconfig: rises 40 clocks after the trigger edge, then HALT.
    do_write(ADDR_TRIG, 32'h1);
    n = 0;
    while (!reconfig_req && n < 200) begin
      n++;
      tick();
    end
    check_val("reconf_delay", n, 40);
    do_write(ADDR_REQ, 32'h1);
    do_write(ADDR_TRIG, 32'h1);
    hold_ok = 1;
    repeat (50) begin
      tick();
      if (busy !== 1'b0 || reconfig_req !== 1'b1) hold_ok = 0;
    end
    check_val("halt_hold", hold_ok, 1);
    do_read(ADDR_BUSY, rd);
    check_val("halt_rd_busy", rd, 32'h0);

    // nreset leaves HALT.
    nreset_pulse();
    check_val("halt_exit_req", {31'b0, reconfig_req}, 32'h0);
    do_write(ADDR_REQ, 32'h1);
    check_val("post_halt_busy", {31'b0, busy}, 32'h1);

    // Asynchronous reset mid-BUSY.
    repeat (3) tick();
    #2 reset_sig = 1'b1;
    #1;
    check_val("async_rst_busy", {31'b0, busy}, 32'h0);
    reset_sig = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
